// File: rtl/miner_pkg.sv
// Shared constants and sweep state encoding for the nonce sweep controller.
package miner_pkg;
  localparam int NONCE_W = 32;
  localparam logic [NONCE_W-1:0] DEFAULT_TARGET = 32'hA41F32E7;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;
endpackage

// File: rtl/gn_fifo.sv
// Golden-nonce FIFO with first-word-fall-through head; a push into a full
// FIFO is accepted when the head is popped in the same cycle.
module gn_fifo
  import miner_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = NONCE_W
) (
  input  logic             hash_clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             write_s;
  logic             read_s;

  assign full    = (count_r == (PTR_W + 1)'(DEPTH));
  assign empty   = (count_r == (PTR_W + 1)'(0));
  assign head    = mem_r[rd_ptr_r];
  assign read_s  = pop & ~empty;
  assign write_s = push & (~full | read_s);

  // Storage, pointers and fill level.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= (PTR_W + 1)'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WIDTH'(0);
      end
    end else begin
      if (write_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (read_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + (PTR_W + 1)'(write_s) - (PTR_W + 1)'(read_s);
    end
  end
endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Multi-core nonce sweep controller: issues interleaved nonce groups, realigns
// core results with their nonces and queues golden nonces for the host.
module nonce_sweep_ctrl
  import miner_pkg::*;
#(
  parameter int                 NUM_CORES    = 1,
  parameter int                 PIPE_LATENCY = 254,
  parameter int                 FIFO_DEPTH   = 8,
  parameter logic [NONCE_W-1:0] TARGET       = DEFAULT_TARGET
) (
  input  logic                           hash_clk,
  input  logic                           reset,
  input  logic                           new_work,
  input  logic [NONCE_W-1:0]             start_nonce,
  output logic [NONCE_W*NUM_CORES-1:0]   core_nonce,
  input  logic [NONCE_W*NUM_CORES-1:0]   core_hash,
  output logic                           running,
  output logic                           exhausted,
  output logic                           gn_valid,
  output logic [NONCE_W-1:0]             gn_nonce,
  input  logic                           gn_ready,
  output logic [7:0]                     drop_count
);
  localparam int                 IDX_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int                 WARM_W     = $clog2(PIPE_LATENCY + 1);
  localparam logic [NONCE_W:0]   STRIDE     = (NONCE_W + 1)'(NUM_CORES);
  localparam logic [NONCE_W-1:0] ALIGN_MASK = ~NONCE_W'(NUM_CORES - 1);

  sweep_state_t                 state_r, next_state_s;
  logic [NONCE_W-1:0]           aligned_s, group_base_r, check_base_r, s1_base_r;
  logic [NONCE_W*NUM_CORES-1:0] core_nonce_r;
  logic [NONCE_W:0]             issue_sum_s, check_sum_s;
  logic [WARM_W-1:0]            warm_r;
  logic                         check_active_r, checking_s, s1_last_r;
  logic [NUM_CORES-1:0]         match_s, match_r;
  logic                         hit_any_s, push_s, pop_s, full_drop_s;
  logic                         fifo_full_s, fifo_empty_s;
  logic [IDX_W-1:0]             hit_idx_s;
  logic [4:0]                   hit_cnt_s, extra_s;
  logic [8:0]                   drop_sum_s;
  logic [7:0]                   drop_r;
  logic                         running_r, exhausted_r;
  logic [NONCE_W-1:0]           fifo_head_s;

  function automatic logic [NONCE_W*NUM_CORES-1:0] nonce_group(input logic [NONCE_W-1:0] base);
    logic [NONCE_W*NUM_CORES-1:0] grp;
    for (int i = 0; i < NUM_CORES; i++) begin
      grp[i*NONCE_W +: NONCE_W] = base + NONCE_W'(i);
    end
    return grp;
  endfunction

  assign aligned_s   = start_nonce & ALIGN_MASK;
  // A carry out of the next group base marks the current group as the last one.
  assign issue_sum_s = {1'b0, group_base_r} + STRIDE;
  assign check_sum_s = {1'b0, check_base_r} + STRIDE;
  assign checking_s  = check_active_r & (warm_r == WARM_W'(0));

  // Next-state decode; new_work restarts the sweep from any state.
  always_comb begin
    next_state_s = state_r;
    if (new_work) begin
      next_state_s = SWEEP;
    end else begin
      case (state_r)
        IDLE:    next_state_s = IDLE;
        SWEEP:   next_state_s = issue_last_s() ? DRAIN : SWEEP;
        DRAIN:   next_state_s = s1_last_r ? DONE : DRAIN;
        DONE:    next_state_s = DONE;
        default: next_state_s = IDLE;
      endcase
    end
  end

  function automatic logic issue_last_s();
    return issue_sum_s[NONCE_W];
  endfunction

  // State register with registered status flags.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      running_r   <= 1'b0;
      exhausted_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      running_r   <= (next_state_s == SWEEP) || (next_state_s == DRAIN);
      exhausted_r <= (next_state_s == DONE);
    end
  end

  // Issue side: advance one nonce group per cycle while sweeping.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      group_base_r <= NONCE_W'(0);
      core_nonce_r <= (NONCE_W * NUM_CORES)'(0);
    end else if (new_work) begin
      group_base_r <= aligned_s;
      core_nonce_r <= nonce_group(aligned_s);
    end else if ((state_r == SWEEP) && !issue_sum_s[NONCE_W]) begin
      group_base_r <= issue_sum_s[NONCE_W-1:0];
      core_nonce_r <= nonce_group(issue_sum_s[NONCE_W-1:0]);
    end
  end

  // Check side: same group sequence as issue, held off by the warm-up count.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      warm_r         <= WARM_W'(0);
      check_active_r <= 1'b0;
      check_base_r   <= NONCE_W'(0);
    end else if (new_work) begin
      warm_r         <= WARM_W'(PIPE_LATENCY);
      check_active_r <= 1'b1;
      check_base_r   <= aligned_s;
    end else begin
      if (warm_r != WARM_W'(0)) begin
        warm_r <= warm_r - WARM_W'(1);
      end
      if (checking_s) begin
        if (check_sum_s[NONCE_W]) begin
          check_active_r <= 1'b0;
        end else begin
          check_base_r <= check_sum_s[NONCE_W-1:0];
        end
      end
    end
  end

  // Per-core target compare.
  always_comb begin
    match_s = NUM_CORES'(0);
    for (int i = 0; i < NUM_CORES; i++) begin
      match_s[i] = checking_s && (core_hash[i*NONCE_W +: NONCE_W] == TARGET);
    end
  end

  // Compare stage 1 register; new_work discards anything in flight.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      match_r   <= NUM_CORES'(0);
      s1_base_r <= NONCE_W'(0);
      s1_last_r <= 1'b0;
    end else if (new_work) begin
      match_r   <= NUM_CORES'(0);
      s1_base_r <= NONCE_W'(0);
      s1_last_r <= 1'b0;
    end else begin
      match_r   <= match_s;
      s1_base_r <= check_base_r;
      s1_last_r <= checking_s & check_sum_s[NONCE_W];
    end
  end

  // Lowest-index priority encode and count of additional hits.
  always_comb begin
    hit_idx_s = IDX_W'(0);
    hit_cnt_s = 5'd0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      hit_idx_s = match_r[i] ? IDX_W'(i) : hit_idx_s;
      hit_cnt_s = hit_cnt_s + 5'(match_r[i]);
    end
    hit_any_s = |match_r;
    extra_s   = hit_any_s ? (hit_cnt_s - 5'd1) : 5'd0;
  end

  assign push_s      = hit_any_s & ~new_work;
  assign pop_s       = gn_ready & ~fifo_empty_s;
  assign full_drop_s = push_s & fifo_full_s & ~pop_s;
  assign drop_sum_s  = {1'b0, drop_r} + 9'(push_s ? extra_s : 5'd0) + 9'(full_drop_s);

  // Saturating drop counter.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      drop_r <= 8'd0;
    end else if (new_work) begin
      drop_r <= 8'd0;
    end else begin
      drop_r <= drop_sum_s[8] ? 8'd255 : drop_sum_s[7:0];
    end
  end

  gn_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_gn_fifo (
    .hash_clk  (hash_clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (s1_base_r + NONCE_W'(hit_idx_s)),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (fifo_head_s)
  );

  assign core_nonce = core_nonce_r;
  assign running    = running_r;
  assign exhausted  = exhausted_r;
  assign gn_valid   = ~fifo_empty_s;
  assign gn_nonce   = fifo_empty_s ? NONCE_W'(0) : fifo_head_s;
  assign drop_count = drop_r;
endmodule
